// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the instruction fetch controller.
//   - fetch_state_e     : FSM state encoding (IDLE, REQ, WAIT, HOLD)
//   - FETCH_TIMEOUT_DEF : default cycle limit in REQ/WAIT before the timeout flag
//   - cnt_width()       : timeout counter width, never narrower than 8 bits
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam int unsigned FETCH_TIMEOUT_DEF = 255;

    function automatic int cnt_width(input int unsigned limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller.
//   clk, rst_n           : clock, asynchronous active-low reset
//   pc / pc_en           : current PC in, one-cycle advance pulse out
//   redirect, stall      : taken jump/branch resolving, decode back-pressure
//   imem_req_*           : request valid/ready handshake, imem_addr = pc
//   imem_rsp_*           : response valid + instruction word
//   instr_valid/instr/instr_pc : fetched instruction presented to decode
//   fetch_timeout        : sticky flag, too long spent in REQ or WAIT
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = FETCH_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_timeout
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);

    fetch_state_e     state;
    logic             discard;
    logic             pc_en_q;
    logic             adv_raw;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W:0]   to_inc;

    // The PC only moves on pc_en, so driving the address straight from pc
    // keeps it stable for the whole request.
    assign imem_addr = pc;
    assign to_inc    = {1'b0, to_cnt} + 1'b1;

    // pc_en is combinational so the PC is already updated in the REQ cycle
    // that follows HOLD; this gives the one-cycle HOLD->request turnaround.
    // Redirect outranks stall; pc_en_q blocks back-to-back pulses.
    always_comb begin
        adv_raw = 1'b0;
        case (state)
            ST_REQ, ST_WAIT: adv_raw = redirect;
            ST_HOLD:         adv_raw = redirect | ~stall;
            default:         adv_raw = 1'b0;
        endcase
    end

    assign pc_en = adv_raw & ~pc_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            fetch_timeout  <= 1'b0;
            instr          <= '0;
            instr_pc       <= '0;
            discard        <= 1'b0;
            to_cnt         <= '0;
            pc_en_q        <= 1'b0;
        end else begin
            pc_en_q <= pc_en;

            // Count cycles spent in REQ/WAIT; transitions below clear it.
            if (state == ST_REQ || state == ST_WAIT) begin
                if (to_cnt != TO_MAX)
                    to_cnt <= to_inc[CNT_W-1:0];
                if (to_inc >= {1'b0, TO_MAX})
                    fetch_timeout <= 1'b1;
            end

            case (state)
                // Enter REQ with valid low: the first request then appears
                // on the second edge after reset release.
                ST_IDLE: begin
                    state  <= ST_REQ;
                    to_cnt <= '0;
                end

                ST_REQ: begin
                    if (!imem_req_valid) begin
                        // one-cycle gap after reset or a redirect
                        imem_req_valid <= 1'b1;
                    end else if (imem_req_ready) begin
                        // accepted; a redirect this cycle makes the reply stale
                        state          <= ST_WAIT;
                        imem_req_valid <= 1'b0;
                        instr_pc       <= pc;
                        discard        <= pc_en;
                        to_cnt         <= '0;
                    end else if (pc_en) begin
                        imem_req_valid <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        to_cnt <= '0;
                        if (discard || pc_en) begin
                            // stale or redirected-over reply: drop and refetch
                            discard        <= 1'b0;
                            state          <= ST_REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_valid <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end else if (pc_en) begin
                        discard <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (pc_en) begin
                        instr_valid    <= 1'b0;
                        state          <= ST_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en;
    logic        redirect;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_timeout;

    // bench-side controls
    logic        auto_rsp;
    logic        man_vld;
    logic [31:0] man_data;
    logic [31:0] tgt;
    logic        acc_q;
    logic [31:0] acc_addr;
    logic        pc_en_d;
    int          pc_en_cnt = 0;
    int          b2b = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .pc_en          (pc_en),
        .redirect       (redirect),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_timeout  (fetch_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model: target on redirect, else +4
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc <= 32'h0;
        else if (pc_en) pc <= redirect ? tgt : pc + 32'd4;
    end

    // memory model: reply one cycle after an accepted request
    always @(posedge clk) begin
        acc_q    <= imem_req_valid && imem_req_ready;
        acc_addr <= imem_addr;
        pc_en_d  <= pc_en;
        if (pc_en) pc_en_cnt <= pc_en_cnt + 1;
        if (pc_en && pc_en_d) b2b <= b2b + 1;
    end

    always @(negedge clk) begin
        if (auto_rsp) begin
            imem_rsp_valid = acc_q;
            imem_rsp_data  = acc_q ? (32'hC0DE_0000 ^ acc_addr) : 32'h0;
        end else begin
            imem_rsp_valid = man_vld;
            imem_rsp_data  = man_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_instr();
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        if (!instr_valid) chk("wait_instr_tmo", 32'd0, 32'd1);
    endtask

    initial begin
        int c0;
        int bad;
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
        auto_rsp = 1'b1; man_vld = 1'b0; man_data = 32'h0; tgt = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_timeout", 32'(fetch_timeout), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        // first request two edges after release
        rst_n = 1'b1;
        tick();
        chk("rel_gap_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rel_req_addr", imem_addr, 32'h0);

        // zero-wait sequential fetch 0,4,8
        for (int i = 0; i < 3; i++) begin
            wait_instr();
            chk("seq_instr", instr, 32'hC0DE_0000 ^ 32'(4 * i));
            chk("seq_instr_pc", instr_pc, 32'(4 * i));
            if (i < 2) begin
                chk("seq_pc_en", 32'(pc_en), 32'd1);
                tick();
                chk("seq_req_valid", 32'(imem_req_valid), 32'd1);
                chk("seq_req_addr", imem_addr, 32'(4 * (i + 1)));
                if (i == 1) stall = 1'b1;
            end
        end
        chk("seq_pc_en_cnt", 32'(pc_en_cnt), 32'd2);

        // stall while holding
        for (int k = 0; k < 3; k++) begin
            chk("stall_iv", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, 32'hC0DE_0008);
            chk("stall_pc", instr_pc, 32'h8);
            chk("stall_pc_en", 32'(pc_en), 32'd0);
            chk("stall_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("resume_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("resume_req", 32'(imem_req_valid), 32'd1);
        chk("resume_addr", imem_addr, 32'hC);
        chk("resume_cnt", 32'(pc_en_cnt), 32'd3);

        // redirect twice in WAIT, stale reply dropped
        auto_rsp = 1'b0;
        tick();
        chk("wr_wait_valid", 32'(imem_req_valid), 32'd0);
        redirect = 1'b1; tgt = 32'h10;
        #1;
        chk("wr_pc_en1", 32'(pc_en), 32'd1);
        tick();
        redirect = 1'b0;
        tick();
        redirect = 1'b1; tgt = 32'h40;
        #1;
        chk("wr_pc_en2", 32'(pc_en), 32'd1);
        tick();
        redirect = 1'b0; man_vld = 1'b1; man_data = 32'hDEADBEEF;
        tick();
        man_vld = 1'b0;
        chk("wr_drop_iv", 32'(instr_valid), 32'd0);
        chk("wr_drop_instr", instr, 32'hC0DE_0008);
        chk("wr_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wr_req_addr", imem_addr, 32'h40);
        auto_rsp = 1'b1;
        wait_instr();
        chk("wr_instr", instr, 32'hC0DE_0040);
        chk("wr_instr_pc", instr_pc, 32'h40);

        // redirect and stall together in HOLD
        stall = 1'b1; redirect = 1'b1; tgt = 32'h80; c0 = pc_en_cnt;
        #1;
        chk("hr_pc_en", 32'(pc_en), 32'd1);
        tick();
        redirect = 1'b0; stall = 1'b0;
        #1;
        chk("hr_iv", 32'(instr_valid), 32'd0);
        chk("hr_pc_en_after", 32'(pc_en), 32'd0);
        chk("hr_cnt", 32'(pc_en_cnt - c0), 32'd1);
        chk("hr_addr", imem_addr, 32'h80);

        // redirect in REQ without ready: one-cycle valid gap
        imem_req_ready = 1'b0;
        tick();
        redirect = 1'b1; tgt = 32'h100;
        #1;
        chk("rr_pc_en", 32'(pc_en), 32'd1);
        tick();
        redirect = 1'b0;
        chk("rr_gap", 32'(imem_req_valid), 32'd0);
        tick();
        chk("rr_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rr_req_addr", imem_addr, 32'h100);
        imem_req_ready = 1'b1;
        wait_instr();
        chk("rr_instr", instr, 32'hC0DE_0100);

        // redirect coincident with ready: accepted, reply discarded
        imem_req_ready = 1'b0;
        tick();
        tick();
        chk("rd_addr_seq", imem_addr, 32'h104);
        redirect = 1'b1; tgt = 32'h200; imem_req_ready = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        chk("rd_drop_iv", 32'(instr_valid), 32'd0);
        chk("rd_req_addr", imem_addr, 32'h200);
        wait_instr();
        chk("rd_instr", instr, 32'hC0DE_0200);
        chk("rd_instr_pc", instr_pc, 32'h200);

        // reset during WAIT, stale reply after release
        auto_rsp = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_req_valid", 32'(imem_req_valid), 32'd0);
        chk("ar_iv", 32'(instr_valid), 32'd0);
        chk("ar_instr", instr, 32'h0);
        chk("ar_instr_pc", instr_pc, 32'h0);
        tick();
        tick();
        rst_n = 1'b1; man_vld = 1'b1; man_data = 32'h1234_5678;
        tick();
        man_vld = 1'b0;
        chk("ar_gap_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("ar_req_valid2", 32'(imem_req_valid), 32'd1);
        chk("ar_req_addr", imem_addr, 32'h0);
        chk("ar_iv2", 32'(instr_valid), 32'd0);
        auto_rsp = 1'b1;
        wait_instr();
        chk("ar_instr2", instr, 32'hC0DE_0000);

        // timeout with ready stuck low
        rst_n = 1'b0; imem_req_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (e >= 2 && (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)) bad++;
            if (pc_en) bad++;
            if (e == 255) chk("to_before", 32'(fetch_timeout), 32'd0);
            if (e == 256) chk("to_set", 32'(fetch_timeout), 32'd1);
        end
        chk("to_req_stable", 32'(bad), 32'd0);
        chk("to_sticky", 32'(fetch_timeout), 32'd1);
        imem_req_ready = 1'b1;
        wait_instr();
        chk("to_instr", instr, 32'hC0DE_0000);
        chk("to_sticky2", 32'(fetch_timeout), 32'd1);

        chk("pc_en_b2b", 32'(b2b), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: the maximum number of cycles allowed in REQ or WAIT before a timeout is flagged.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 pc  input  32  current program counter from the PC register.
REQ-005 pc_en  output  1  one-cycle pulse; the PC register SHALL advance (sequential, jump or branch) on the next edge.
REQ-006 redirect  input  1  a taken jal, jalr or branch is resolving this cycle.
REQ-007 stall  input  1  decode cannot accept an instruction this cycle.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  instruction memory accepts the request.
REQ-010 imem_addr  output  32  fetch address.
REQ-011 imem_rsp_valid  input  1  response data valid; exactly one response per accepted request.
REQ-012 imem_rsp_data  input  32  instruction word.
REQ-013 instr_valid  output  1  instr and instr_pc are valid for decode.
REQ-014 instr  output  32  fetched instruction.
REQ-015 instr_pc  output  32  address of instr.
REQ-016 fetch_timeout  output  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, HOLD; at most one request outstanding.
REQ-018 IDLE: go to REQ on the next cycle after reset release.
REQ-019 REQ: drive imem_req_valid=1 and imem_addr=pc; on imem_req_ready go to WAIT and latch pc into instr_pc.
REQ-020 Once valid is asserted, imem_addr SHALL stay stable until ready, unless redirect occurs.
REQ-021 WAIT: on imem_rsp_valid with no discard pending, register imem_rsp_data into instr and go to HOLD.
REQ-022 HOLD: drive instr_valid=1; when stall=0, pulse pc_en and go to REQ.
REQ-023 Sequential fetch: HOLD to REQ to request handshake SHALL take 1 cycle; the new request SHALL use the updated pc.
REQ-024 redirect in HOLD: pulse pc_en, drop the held instruction (instr_valid=0 the next cycle) and go to REQ.
REQ-025 redirect in REQ: pulse pc_en, deassert imem_req_valid for 1 cycle, then re-request with the new pc.
- A simultaneous imem_req_ready SHALL still count as an accepted request; the controller SHALL go to WAIT with discard set.
REQ-026 redirect in WAIT: set discard and pulse pc_en.
- The next response SHALL be dropped, discard cleared, and the controller SHALL go to REQ.
- A response arriving in the same cycle as redirect SHALL itself be dropped; discard SHALL not be set.
REQ-027 redirect SHALL take priority over stall; pc_en SHALL never pulse on two consecutive cycles.
REQ-028 Timeout counter: an 8-bit minimum counter SHALL count cycles in REQ or WAIT and clear on any state change.
- When it reaches TIMEOUT_CYC, fetch_timeout SHALL set and hold until reset.
- The counter SHALL saturate; the FSM SHALL continue waiting.
REQ-029 imem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-030 Asynchronous assertion SHALL force the following, regardless of clk:
- state=IDLE;
- imem_req_valid=0, pc_en=0, instr_valid=0, fetch_timeout=0;
- instr=0, instr_pc=0;
- discard=0, timeout counter=0.
REQ-031 Reset mid-transaction SHALL abandon any outstanding response; the first post-reset request SHALL be issued 2 cycles after rst_n rises.

Structure
REQ-032 The FSM state encoding and the TIMEOUT_CYC default SHALL reside in the shared core package.
REQ-033 The block SHALL be a single module, with no sub-modules.

Verification
REQ-034 Zero-wait memory (ready=1, rsp 1 cycle later), stall=0, pc 0,4,8 -> instr_valid for 0x0,0x4,0x8, one pc_en per instruction.
REQ-035 stall=1 for 3 cycles while in HOLD -> instr and instr_pc held stable, no pc_en and no request, resume after stall drops.
REQ-036 redirect in WAIT with pc 0x10 then 0x40, rsp 0xDEADBEEF arrives -> 0xDEADBEEF dropped, next request addr 0x40.
REQ-037 imem_req_ready=0 for 300 cycles -> fetch_timeout=1 at cycle 255 and sticky, imem_addr stable throughout.
REQ-038 rst_n low during WAIT, then stale rsp arrives after release -> ignored; first request at addr 0x0 is 2 cycles after release.
REQ-039 redirect and stall both high in HOLD -> exactly one pc_en, instr_valid=0 next cycle.
